fixed_to_float_pipe: RTL and testbench

- Pipelined, parametrised fixed-point to IEEE-754 single-precision converter for the CORDIC datapath.
- Successor to the single-range combinational converter. Accepts any signed or unsigned fixed-point format and normalises it fully with a leading-one search.
- Optionally rounds to nearest even.
- Sits between the CORDIC core output and the custom-instruction result register, using a valid/ready handshake with backpressure.

---
 rtl/fixed_to_float_pipe.sv | 167 ++++++++++++++++
 tb/tb_fixed_to_float_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_pipe.sv
// fixed_to_float_pipe
// Three-stage pipelined converter from a parametrised fixed-point word
// (signed or unsigned) to an IEEE-754 single-precision value, with a
// valid/ready handshake and full backpressure.
//   S1: sign/magnitude split and zero detect
//   S2: leading-one search, exponent and normalising shift
//   S3: mantissa extraction, optional rounding, pack
// Optional macro FIXED_TO_FLOAT_RNE_EN: when defined, S3 rounds to nearest,
// ties to even. When undefined, S3 truncates and no guard/sticky logic is built.
module fixed_to_float_pipe #(
    parameter int INTS   = 1,
    parameter int FRACS  = 20,
    parameter int SIGNED = 0,
    parameter int WIDTH  = SIGNED + INTS + FRACS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_fixed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float
);

    // Normalised word padded on the LSB side so that the 23 mantissa bits,
    // the guard bit and at least one sticky bit always exist; for narrow
    // inputs the padding is zero, which yields zero-fill with no rounding.
    localparam int PADW = WIDTH + 25;

    // Stage advance chain
    logic adv1;
    logic adv2;
    logic adv3;

    // Stage valid bits
    logic v1;
    logic v2;
    logic v3;

    // S1 registers
    logic             sign1;
    logic             zero1;
    logic [WIDTH-1:0] mag1;

    // S2 registers
    logic             sign2;
    logic             zero2;
    logic [7:0]       exp2;
    logic [WIDTH-1:0] norm2;

    // Combinational stage logic
    logic             sign_c;
    logic [WIDTH-1:0] mag_c;
    int unsigned      lead;
    logic [7:0]       exp_c;
    logic [WIDTH-1:0] norm_c;
    logic [PADW-1:0]  ext;
    logic [22:0]      mant_c;
    logic [7:0]       exp_r;
    logic [31:0]      float_c;
    logic             unused_bits;

`ifdef FIXED_TO_FLOAT_RNE_EN
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [23:0]      mant_rnd;
`endif

    assign adv3      = !v3 | out_ready;
    assign adv2      = !v2 | adv3;
    assign adv1      = !v1 | adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // S1 combinational: split sign and form the unsigned magnitude
    always_comb begin
        sign_c = (SIGNED != 0) ? in_fixed[WIDTH-1] : 1'b0;
        mag_c  = sign_c ? (-in_fixed) : in_fixed;
    end

    // S2 combinational: leading-one position, biased exponent, normalising shift
    always_comb begin
        lead = 0;
        // The last shift that still leaves a nonzero value is the MSB position.
        for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
            if ((mag1 >> i) != '0) begin
                lead = i;
            end
        end
        exp_c  = 8'(127 + lead - FRACS);
        norm_c = mag1 << (WIDTH - 1 - lead);
    end

    assign ext         = {norm2, 25'b0};
    assign unused_bits = ^ext;

    // S3 combinational: take the 23 bits below the leading one, round, pack
    always_comb begin
        mant_c = ext[PADW-2 -: 23];
        exp_r  = exp2;
`ifdef FIXED_TO_FLOAT_RNE_EN
        guard    = ext[PADW-25];
        sticky   = |ext[PADW-26:0];
        round_up = guard & (sticky | mant_c[0]);
        mant_rnd = {1'b0, mant_c} + {23'b0, round_up};
        if (mant_rnd[23]) begin
            mant_c = '0;
            exp_r  = exp2 + 8'd1;
        end else begin
            mant_c = mant_rnd[22:0];
        end
`endif
        float_c = zero2 ? '0 : {sign2, exp_r, mant_c};
    end

    // S1 register: load a new word whenever the stage advances
    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            zero1 <= 1'b0;
            mag1  <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                sign1 <= sign_c;
                zero1 <= (mag_c == '0);
                mag1  <= mag_c;
            end
        end
    end

    // S2 register: capture normalised magnitude and exponent from S1
    always_ff @(posedge clk) begin
        if (reset) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            zero2 <= 1'b0;
            exp2  <= '0;
            norm2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                sign2 <= sign1;
                zero2 <= zero1;
                exp2  <= exp_c;
                norm2 <= norm_c;
            end
        end
    end

    // S3 register: packed result, held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            v3        <= 1'b0;
            out_float <= '0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                out_float <= float_c;
            end
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// tb_fixed_to_float_pipe
// Directed, table-driven bench for fixed_to_float_pipe. Three instances cover
// the default unsigned format, a signed format and a 32-bit integer format.
// Expected values for rounding cases follow FIXED_TO_FLOAT_RNE_EN.
module tb_fixed_to_float_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: INTS=1, FRACS=20, unsigned (WIDTH=21)
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [20:0] a_in_fixed;
    logic [31:0] a_out_float;

    // Instance B: INTS=1, FRACS=20, signed (WIDTH=22)
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [21:0] b_in_fixed;
    logic [31:0] b_out_float;

    // Instance C: INTS=32, FRACS=0, unsigned (WIDTH=32)
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_fixed;
    logic [31:0] c_out_float;

    fixed_to_float_pipe dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_fixed  (a_in_fixed),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_float (a_out_float)
    );

    fixed_to_float_pipe #(.INTS(1), .FRACS(20), .SIGNED(1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_fixed  (b_in_fixed),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_float (b_out_float)
    );

    fixed_to_float_pipe #(.INTS(32), .FRACS(0), .SIGNED(0)) dut_c (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_fixed  (c_in_fixed),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_float (c_out_float)
    );

`ifdef FIXED_TO_FLOAT_RNE_EN
    localparam logic [31:0] C_ODD_TIE  = 32'h4B80_0002;
    localparam logic [31:0] C_ALL_ONES = 32'h4F80_0000;
    localparam logic [31:0] C_ROUND_7  = 32'h4B80_0004;
`else
    localparam logic [31:0] C_ODD_TIE  = 32'h4B80_0001;
    localparam logic [31:0] C_ALL_ONES = 32'h4F7F_FFFF;
    localparam logic [31:0] C_ROUND_7  = 32'h4B80_0003;
`endif

    typedef struct packed {
        logic [1:0]  cfg;
        logic [63:0] din;
        logic [31:0] want;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic set_in(input logic [1:0] cfg, input logic v, input logic [63:0] d);
        case (cfg)
            2'd0: begin a_in_valid = v; a_in_fixed = d[20:0]; end
            2'd1: begin b_in_valid = v; b_in_fixed = d[21:0]; end
            default: begin c_in_valid = v; c_in_fixed = d[31:0]; end
        endcase
    endtask

    function automatic logic get_in_ready(input logic [1:0] cfg);
        case (cfg)
            2'd0:    return a_in_ready;
            2'd1:    return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    function automatic logic get_out_valid(input logic [1:0] cfg);
        case (cfg)
            2'd0:    return a_out_valid;
            2'd1:    return b_out_valid;
            default: return c_out_valid;
        endcase
    endfunction

    function automatic logic [31:0] get_out_float(input logic [1:0] cfg);
        case (cfg)
            2'd0:    return a_out_float;
            2'd1:    return b_out_float;
            default: return c_out_float;
        endcase
    endfunction

    // Send one word, then measure latency (acceptance cycle counts as 0) and value.
    task automatic run_one(input logic [1:0] cfg, input logic [63:0] din,
                           input logic [31:0] want, input string name);
        int lat;
        @(posedge clk); #1;
        set_in(cfg, 1'b1, din);
        check({name, "_in_ready"}, 64'(get_in_ready(cfg)), 64'd1);
        @(posedge clk); #1;
        set_in(cfg, 1'b0, '0);
        lat = 1;
        while (!get_out_valid(cfg) && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd3);
        check({name, "_value"}, 64'(get_out_float(cfg)), 64'(want));
    endtask

    // Stop the run if anything wedges the bench itself.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    logic [20:0] bp_words [8];
    logic [31:0] bp_wants [8];
    logic [20:0] rst_words [3];

    initial begin
        vecs[0]  = '{2'd0, 64'h10_0000, 32'h3F80_0000};
        vecs[1]  = '{2'd0, 64'h08_0000, 32'h3F00_0000};
        vecs[2]  = '{2'd0, 64'h00_0001, 32'h3580_0000};
        vecs[3]  = '{2'd0, 64'h00_0000, 32'h0000_0000};
        vecs[4]  = '{2'd0, 64'h1F_FFFF, 32'h3FFF_FFF8};
        vecs[5]  = '{2'd1, 64'h30_0000, 32'hBF80_0000};
        vecs[6]  = '{2'd1, 64'h20_0000, 32'hC000_0000};
        vecs[7]  = '{2'd1, 64'h3F_FFFF, 32'hB580_0000};
        vecs[8]  = '{2'd1, 64'h1F_FFFF, 32'h3FFF_FFF8};
        vecs[9]  = '{2'd2, 64'h0100_0003, C_ODD_TIE};
        vecs[10] = '{2'd2, 64'hFFFF_FFFF, C_ALL_ONES};
        vecs[11] = '{2'd2, 64'h0100_0001, 32'h4B80_0000};
        vecs[12] = '{2'd2, 64'h0100_0007, C_ROUND_7};
        vecs[13] = '{2'd2, 64'h0000_0001, 32'h3F80_0000};

        bp_words[0] = 21'h10_0000; bp_wants[0] = 32'h3F80_0000;
        bp_words[1] = 21'h08_0000; bp_wants[1] = 32'h3F00_0000;
        bp_words[2] = 21'h00_0001; bp_wants[2] = 32'h3580_0000;
        bp_words[3] = 21'h00_0000; bp_wants[3] = 32'h0000_0000;
        bp_words[4] = 21'h04_0000; bp_wants[4] = 32'h3E80_0000;
        bp_words[5] = 21'h18_0000; bp_wants[5] = 32'h3FC0_0000;
        bp_words[6] = 21'h1F_FFFF; bp_wants[6] = 32'h3FFF_FFF8;
        bp_words[7] = 21'h0C_0000; bp_wants[7] = 32'h3F40_0000;

        rst_words[0] = 21'h10_0000;
        rst_words[1] = 21'h08_0000;
        rst_words[2] = 21'h18_0000;

        reset = 1'b1;
        a_in_valid = 1'b0; a_in_fixed = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_fixed = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_fixed = '0; c_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_out_float", 64'(a_out_float), 64'd0);
        check("rst_c_out_valid", 64'(c_out_valid), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);

        // Single-word vectors
        for (int i = 0; i < NVEC; i++) begin
            run_one(vecs[i].cfg, vecs[i].din, vecs[i].want, $sformatf("vec%0d", i));
        end

        // Backpressure stream: consumer stalls for cycles 4..7
        begin
            int sent;
            int recv;
            sent = 0;
            recv = 0;
            for (int cyc = 0; cyc < 30; cyc++) begin
                @(posedge clk); #1;
                a_out_ready = !(cyc >= 4 && cyc <= 7);
                if (sent < 8) begin
                    a_in_valid = 1'b1;
                    a_in_fixed = bp_words[sent];
                end else begin
                    a_in_valid = 1'b0;
                    a_in_fixed = '0;
                end
                #2;
                if (cyc < 10) begin
                    check($sformatf("bp_in_ready_c%0d", cyc), 64'(a_in_ready),
                          (cyc >= 4 && cyc <= 7) ? 64'd0 : 64'd1);
                end
                if (a_out_valid && recv < 8) begin
                    check($sformatf("bp_out%0d_c%0d", recv, cyc), 64'(a_out_float), 64'(bp_wants[recv]));
                end
                if (a_in_valid && a_in_ready) sent++;
                if (a_out_valid && a_out_ready) recv++;
            end
            a_out_ready = 1'b1;
            check("bp_sent", 64'(sent), 64'd8);
            check("bp_recv", 64'(recv), 64'd8);
        end

        // Reset with three words in flight
        begin
            int seen;
            a_out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                a_in_valid = 1'b1;
                a_in_fixed = rst_words[k];
            end
            @(posedge clk); #1;
            a_in_valid = 1'b0;
            a_in_fixed = '0;
            check("mid_full_out_valid", 64'(a_out_valid), 64'd1);
            check("mid_full_in_ready", 64'(a_in_ready), 64'd0);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
            check("mid_rst_out_float", 64'(a_out_float), 64'd0);
            check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
            a_out_ready = 1'b1;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (a_out_valid) seen++;
            end
            check("mid_rst_stale_outputs", 64'(seen), 64'd0);
            run_one(2'd0, 64'h18_0000, 32'h3FC0_0000, "mid_rst_new");
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
